// File: rtl/serial_cmd_receiver.sv
// serial_cmd_receiver: SPI-style command deserialiser with readback, latch stretch and error pulses.
// Optional odd-parity bit per frame enabled by defining CMD_PARITY_EN.
module serial_cmd_receiver #(
  parameter int WORD_BITS    = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int LATCH_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 sclk,
  input  logic                 csb,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic [WORD_BITS-1:0] cmd_data,
  output logic                 latch_data,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 parity_error,
  output logic [7:0]           frame_count
);
`ifdef CMD_PARITY_EN
  localparam int N = WORD_BITS + 1;
`else
  localparam int N = WORD_BITS;
`endif
  localparam int CW = $clog2(N + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, LATCH} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_y, csb_y, mosi_y;
  logic                   sclk_q, csb_q;
  logic [N-1:0]           rx;
  logic [WORD_BITS-1:0]   tx;
  logic [CW-1:0]          bit_cnt;
  logic [3:0]             latch_cnt;
  logic                   sclk_s, csb_s, mosi_s, sclk_rise, sclk_fall, csb_rise, parity_ok;
  logic [WORD_BITS-1:0]   payload;
  assign sclk_s    = sclk_y[SYNC_STAGES-1];
  assign csb_s     = csb_y[SYNC_STAGES-1];
  assign mosi_s    = mosi_y[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign csb_rise  = csb_s & ~csb_q;
`ifdef CMD_PARITY_EN
  assign payload   = rx[N-1:1];
  assign parity_ok = ^rx;
`else
  assign payload   = rx;
  assign parity_ok = 1'b1;
`endif
  assign miso       = tx[WORD_BITS-1];
  assign miso_oe    = ~csb_s;
  assign latch_data = latch_cnt != 4'd0;
  // csb synchroniser resets high so an idle bus does not look like a frame start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sclk_y       <= '0;
      csb_y        <= '1;
      mosi_y       <= '0;
      sclk_q       <= 1'b0;
      csb_q        <= 1'b1;
      rx           <= '0;
      tx           <= '0;
      bit_cnt      <= '0;
      latch_cnt    <= '0;
      cmd_data     <= '0;
      frame_count  <= '0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      sclk_y       <= {sclk_y[SYNC_STAGES-2:0], sclk};
      csb_y        <= {csb_y[SYNC_STAGES-2:0], csb};
      mosi_y       <= {mosi_y[SYNC_STAGES-2:0], mosi};
      sclk_q       <= sclk_s;
      csb_q        <= csb_s;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
      parity_error <= 1'b0;
      if (latch_cnt != 4'd0) latch_cnt <= latch_cnt - 4'd1;
      case (state)
        IDLE: if (!csb_s) begin
          state   <= SHIFT;
          bit_cnt <= '0;
          tx      <= cmd_data;
        end
        SHIFT: if (csb_rise) state <= CHECK;
        else begin
          if (sclk_rise) begin
            rx <= (rx << 1) | N'(mosi_s);
            if (bit_cnt != CW'(N + 1)) bit_cnt <= bit_cnt + CW'(1);
          end
          if (sclk_fall) tx <= tx << 1;
        end
        // word is committed on the CHECK->LATCH edge so cmd_data leads latch_data by one cycle
        CHECK: begin
          state <= IDLE;
          if (bit_cnt != CW'(N)) frame_error <= 1'b1;
          else if (!parity_ok) parity_error <= 1'b1;
          else if (latch_cnt != 4'd0) overrun <= 1'b1;
          else begin
            state       <= LATCH;
            cmd_data    <= payload;
            frame_count <= frame_count + 8'd1;
          end
        end
        LATCH: begin
          latch_cnt <= 4'(LATCH_CYCLES);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
